// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding and grant-select codes.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CPU_RDATA = 2'd1,
      CPU_HOLD  = 2'd2,
      DMA_RDATA = 2'd3
   } state_t;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_CPU  = 2'd1;
   localparam logic [1:0] GNT_DMA  = 2'd2;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant select for the shared RAM. SRAM_ARB_RR_EN selects two-way round-robin;
// otherwise fixed priority, CPU over DMA.
module sram_arb_grant
   import sram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_pend,
   input  logic       dma_pend,
   input  logic       idle,
   output logic [1:0] gnt
);

`ifdef SRAM_ARB_RR_EN
   // Pointer starts at DMA so the CPU wins the first tie.
   logic last_dma_q, last_dma_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_dma_q <= 1'b1;
      else     last_dma_q <= last_dma_d;
   end

   always_comb begin
      gnt        = GNT_NONE;
      last_dma_d = last_dma_q;
      if (idle) begin
         if (cpu_pend && dma_pend) gnt = last_dma_q ? GNT_CPU : GNT_DMA;
         else if (cpu_pend)        gnt = GNT_CPU;
         else if (dma_pend)        gnt = GNT_DMA;
      end
      if (gnt == GNT_CPU)      last_dma_d = 1'b0;
      else if (gnt == GNT_DMA) last_dma_d = 1'b1;
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   always_comb begin
      gnt = GNT_NONE;
      if (idle) begin
         if (cpu_pend)      gnt = GNT_CPU;
         else if (dma_pend) gnt = GNT_DMA;
      end
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous RAM between the AVR SRAM bus and a DMA
// requester. Arbitration mode is set by SRAM_ARB_RR_EN (see sram_arb_grant).
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cpu_a,
   input  logic                  cpu_cs,
   input  logic                  cpu_oe,
   input  logic                  cpu_we,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_wait,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic                  dma_ack,
   output logic [DATA_WIDTH-1:0] dma_rdata,
   output logic                  dma_rvalid,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0]   dma_rdata_q, dma_rdata_d;
   logic                    dma_rvalid_q, dma_rvalid_d;
   logic                    cpu_acc;
   logic [1:0]              gnt;

   assign cpu_acc    = cpu_cs & (cpu_oe | cpu_we);
   assign cpu_wait   = cpu_acc & (state_q != CPU_HOLD);
   assign cpu_rdata  = cpu_rdata_q;
   assign dma_rdata  = dma_rdata_q;
   assign dma_rvalid = dma_rvalid_q;

   // Gating the IDLE qualifier with rst keeps the RAM port quiet during reset.
   sram_arb_grant u_grant (
      .clk      (clk),
      .rst      (rst),
      .cpu_pend (cpu_acc),
      .dma_pend (dma_req),
      .idle     ((state_q == IDLE) & ~rst),
      .gnt      (gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         dma_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         dma_rvalid_q <= dma_rvalid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (gnt == GNT_CPU)      state_d = cpu_we ? CPU_HOLD : CPU_RDATA;
            else if (gnt == GNT_DMA) state_d = dma_we ? IDLE : DMA_RDATA;
         end
         CPU_RDATA: state_d = CPU_HOLD;
         CPU_HOLD:  state_d = IDLE;
         DMA_RDATA: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      dma_ack      = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      dma_rvalid_d = 1'b0;
      if (gnt == GNT_CPU) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_a;
         mem_wdata = cpu_wdata;
      end else if (gnt == GNT_DMA) begin
         mem_en    = 1'b1;
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         dma_ack   = 1'b1;
      end
      if (state_q == CPU_RDATA) cpu_rdata_d = mem_rdata;
      if (state_q == DMA_RDATA) begin
         dma_rdata_d  = mem_rdata;
         dma_rvalid_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural RAM and read scoreboards.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cpu_a = '0;
   logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic        cpu_wait;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [15:0] dma_addr = '0;
   logic [7:0]  dma_wdata = '0;
   logic        dma_ack;
   logic [7:0]  dma_rdata;
   logic        dma_rvalid;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   int rv_cnt   = 0;
   logic [7:0] cpu_q[$];
   logic [7:0] dma_q[$];
   logic [7:0] ram [0:65535];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   always @(negedge clk) if (dma_rvalid) rv_cnt++;

   sram_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_a(cpu_a), .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Runs one AVR access; returns the number of cycles wait was high.
   task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                             output int waits);
      @(negedge clk);
      cpu_cs = 1'b1; cpu_we = wr; cpu_oe = ~wr; cpu_a = a; cpu_wdata = d;
      #1;
      waits = 0;
      while (cpu_wait && waits < 20) begin
         waits++;
         @(negedge clk); #1;
      end
      cpu_cs = 1'b0; cpu_we = 1'b0; cpu_oe = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if ({mem_en, mem_we, dma_ack, dma_rvalid} !== 4'b0 || cpu_rdata !== 8'h0 ||
          dma_rdata !== 8'h0 || mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: en=%b we=%b ack=%b rv=%b crd=%h drd=%h addr=%h wd=%h, want all 0",
                  mem_en, mem_we, dma_ack, dma_rvalid, cpu_rdata, dma_rdata, mem_addr, mem_wdata);
      end
      cpu_cs = 1'b1; cpu_oe = 1'b1; #1;
      n_checks++;
      if (cpu_wait !== 1'b1) begin
         n_fail++; $display("FAIL reset_wait_follows_acc: got %b want 1", cpu_wait);
      end
      cpu_cs = 1'b0; cpu_oe = 1'b0; #1;
      n_checks++;
      if (cpu_wait !== 1'b0) begin
         n_fail++; $display("FAIL reset_wait_idle: got %b want 0", cpu_wait);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cpu_write_read;
      int w;
      cpu_access(1'b1, 16'h0123, 8'hA5, w);
      n_checks++;
      if (w != 1) begin n_fail++; $display("FAIL cpu_write_wait: got %0d cycles want 1", w); end
      cpu_q.push_back(8'hA5);
      cpu_access(1'b0, 16'h0123, 8'h00, w);
      n_checks++;
      if (w != 2) begin n_fail++; $display("FAIL cpu_read_wait: got %0d cycles want 2", w); end
      n_checks++;
      if (cpu_rdata !== cpu_q[0]) begin
         n_fail++; $display("FAIL cpu_read_data: got %h want %h", cpu_rdata, cpu_q[0]);
      end
      void'(cpu_q.pop_front());
      @(negedge clk);
   endtask

   task automatic test_dma_burst;
      int k;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200 + 16'(i); dma_wdata = 8'h10 + 8'(i);
         #1;
         n_checks++;
         if (dma_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0200 + 16'(i)) begin
            n_fail++;
            $display("FAIL dma_write_ack%0d: ack=%b we=%b addr=%h want 1 1 %h",
                     i, dma_ack, mem_we, mem_addr, 16'h0200 + 16'(i));
         end
      end
      @(negedge clk);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
      #1;
      for (int i = 0; i < 4; i++) begin
         k = 0;
         while (!dma_ack && k < 8) begin @(negedge clk); #1; k++; end
         n_checks++;
         if (dma_ack !== 1'b1 || k != 0) begin
            n_fail++; $display("FAIL dma_read_ack%0d: ack=%b after %0d extra cycles, want 1 after 0", i, dma_ack, k);
         end
         dma_q.push_back(8'h10 + 8'(i));
         @(negedge clk); #1;
         n_checks++;
         if (dma_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL dma_rvalid_early%0d: got %b want 0", i, dma_rvalid);
         end
         if (i < 3) dma_addr = 16'h0200 + 16'(i + 1);
         else       dma_req  = 1'b0;
         @(negedge clk); #1;
         n_checks++;
         if (dma_rvalid !== 1'b1 || dma_rdata !== dma_q[0]) begin
            n_fail++;
            $display("FAIL dma_read_data%0d: rvalid=%b data=%h want 1 %h", i, dma_rvalid, dma_rdata, dma_q[0]);
         end
         void'(dma_q.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic test_collision_fixed;
      int cyc;
      @(negedge clk);
      cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h0123;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'h77;
      #1;
      n_checks++;
      if (mem_addr !== 16'h0123 || dma_ack !== 1'b0 || mem_we !== 1'b0) begin
         n_fail++; $display("FAIL coll_cpu_first: addr=%h ack=%b we=%b want 0123 0 0", mem_addr, dma_ack, mem_we);
      end
      cpu_q.push_back(8'hA5);
      cyc = 0;
      while (!dma_ack && cyc < 10) begin
         @(negedge clk); #1; cyc++;
         if (cpu_cs && !cpu_wait) begin
            n_checks++;
            if (cpu_rdata !== cpu_q[0]) begin
               n_fail++; $display("FAIL coll_cpu_data: got %h want %h", cpu_rdata, cpu_q[0]);
            end
            void'(cpu_q.pop_front());
            cpu_cs = 1'b0; cpu_oe = 1'b0; #1;
         end
      end
      n_checks++;
      if (cyc != 3 || mem_addr !== 16'h0300 || mem_we !== 1'b1) begin
         n_fail++; $display("FAIL coll_dma_ack: after %0d cycles addr=%h we=%b want 3 0300 1", cyc, mem_addr, mem_we);
      end
      n_checks++;
      if (cpu_q.size() != 0) begin
         n_fail++; $display("FAIL coll_cpu_done: %0d reads outstanding want 0", cpu_q.size());
      end
      cpu_q.delete();
      @(negedge clk); dma_req = 1'b0; dma_we = 1'b0; cpu_cs = 1'b0; cpu_oe = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_read;
      int rv0, k;
      @(negedge clk);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0201;
      #1;
      n_checks++;
      if (dma_ack !== 1'b1) begin n_fail++; $display("FAIL rst_read_ack: got %b want 1", dma_ack); end
      rv0 = rv_cnt;
      @(negedge clk);
      rst = 1'b1; dma_req = 1'b0;
      #1;
      n_checks++;
      if ({mem_en, mem_we, dma_ack, dma_rvalid} !== 4'b0 || cpu_rdata !== 8'h0 ||
          dma_rdata !== 8'h0 || mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: en=%b we=%b ack=%b rv=%b crd=%h drd=%h addr=%h wd=%h, want all 0",
                  mem_en, mem_we, dma_ack, dma_rvalid, cpu_rdata, dma_rdata, mem_addr, mem_wdata);
      end
      @(negedge clk); @(negedge clk); rst = 1'b0;
      @(negedge clk); @(negedge clk);
      n_checks++;
      if (rv_cnt != rv0) begin
         n_fail++; $display("FAIL rst_dropped_rvalid: got %0d pulses want 0", rv_cnt - rv0);
      end
      dma_req = 1'b1; dma_addr = 16'h0202;
      #1;
      k = 0;
      while (!dma_ack && k < 8) begin @(negedge clk); #1; k++; end
      n_checks++;
      if (dma_ack !== 1'b1) begin n_fail++; $display("FAIL rst_after_ack: got %b want 1", dma_ack); end
      dma_q.push_back(8'h12);
      @(negedge clk); dma_req = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== dma_q[0]) begin
         n_fail++; $display("FAIL rst_after_data: rvalid=%b data=%h want 1 %h", dma_rvalid, dma_rdata, dma_q[0]);
      end
      void'(dma_q.pop_front());
      @(negedge clk);
   endtask

`ifdef SRAM_ARB_RR_EN
   task automatic test_round_robin;
      int g[$];
      int k;
      logic [1:0] want [4];
      want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd1; want[3] = 2'd2;
      @(negedge clk);
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_a = 16'h0400; cpu_wdata = 8'h55;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0500; dma_wdata = 8'h66;
      #1;
      k = 0;
      while (g.size() < 4 && k < 20) begin
         if (mem_en) g.push_back(dma_ack ? 2 : 1);
         @(negedge clk); #1; k++;
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= g.size() || g[i] != int'(want[i])) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got %0d want %0d (1=cpu 2=dma)", i, (i < g.size()) ? g[i] : 0, want[i]);
         end
      end
      cpu_cs = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
      @(negedge clk); @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_cpu_write_read();
      test_dma_burst();
      test_collision_fixed();
      test_reset_mid_read();
`ifdef SRAM_ARB_RR_EN
      test_round_robin();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares one single-port synchronous block RAM between the AVR core's external SRAM bus and a DMA requester, e.g. a CD sector buffer filler. It sits between the AVR `sram_*` pins and the buffer RAM. It sequences each access through a small FSM and stalls the CPU with a combinational wait. DMA uses a req/ack handshake with a registered read-data return.

## Interface
- `ADDR_WIDTH`, 16, address width of CPU, DMA and RAM ports.
- `DATA_WIDTH`, 8, data width.

- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_a`  in  ADDR_WIDTH  AVR SRAM address.
- `cpu_cs`  in  1  AVR chip select.
- `cpu_oe`  in  1  AVR read strobe.
- `cpu_we`  in  1  AVR write strobe.
- `cpu_wdata`  in  DATA_WIDTH  write data from AVR.
- `cpu_rdata`  out  DATA_WIDTH  registered read data to AVR.
- `cpu_wait`  out  1  stall to AVR (combinational).
- `dma_req`  in  1  DMA request. Address, data and direction must be held stable until ack.
- `dma_we`  in  1  1 = write, 0 = read.
- `dma_addr`  in  ADDR_WIDTH  DMA address.
- `dma_wdata`  in  DATA_WIDTH  DMA write data.
- `dma_ack`  out  1  one-cycle pulse in the issue cycle.
- `dma_rdata`  out  DATA_WIDTH  registered read data.
- `dma_rvalid`  out  1  one-cycle pulse qualifying `dma_rdata`.
- `mem_en`  out  1  RAM enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_wdata`  out  DATA_WIDTH  RAM write data.
- `mem_rdata`  in  DATA_WIDTH  RAM read data, valid the cycle after `mem_en` with `mem_we` = 0.

## Operation
- CPU access pending: `cpu_acc = cpu_cs & (cpu_oe | cpu_we)`. If `cpu_oe` and `cpu_we` are both high, treat it as a write.
- `cpu_wait = cpu_acc & (state != CPU_HOLD)`.
- FSM states: IDLE, CPU_RDATA, CPU_HOLD, DMA_RDATA. Reset state is IDLE.
- IDLE arbitrates among the CPU and DMA requests that are pending in that cycle:
  - CPU write: drive `mem_en`=`mem_we`=1 with `cpu_a`/`cpu_wdata`, then go to CPU_HOLD.
  - CPU read: drive `mem_en`=1, then go to CPU_RDATA.
  - DMA write: drive the RAM, pulse `dma_ack`, stay in IDLE. Back-to-back DMA writes run at 1 per cycle.
  - DMA read: drive the RAM, pulse `dma_ack`, then go to DMA_RDATA.
- CPU_RDATA: register `mem_rdata` into `cpu_rdata`, then go to CPU_HOLD.
- CPU_HOLD: `cpu_wait`=0 so the AVR completes. No RAM access is issued. Go to IDLE unconditionally.
- DMA_RDATA: register `mem_rdata` into `dma_rdata` and set `dma_rvalid` for the next cycle. No RAM access is issued. Go to IDLE.
- Arbitration is fixed priority, CPU over DMA (see Configuration).
- `cpu_rdata` holds its value until the next CPU read capture.
- `dma_rdata` holds its value; `dma_rvalid` is a single-cycle pulse.
- Reset, asserted at any point including mid-access:
  - FSM returns to IDLE.
  - `mem_en`, `mem_we`, `dma_ack`, `dma_rvalid`, `cpu_rdata`, `dma_rdata`, `mem_addr` and `mem_wdata` are all 0.
  - Any in-flight read is dropped with no `dma_rvalid`.
  - `cpu_wait` follows `cpu_acc` while reset is asserted.

## Timing
- The RAM outputs (`mem_en`, `mem_we`, `mem_addr`, `mem_wdata`) and `dma_ack` are combinational decodes of the state and requests in the grant cycle T.
- CPU write: grant at T with wait=1. Wait=0 at T+1. Total 2 cycles.
- CPU read: grant at T, capture at T+1, wait=0 with `cpu_rdata` valid at T+2. Total 3 cycles.
- DMA read: ack at T, `dma_rvalid` at T+2. The next grant is possible at T+2.
- DMA write: ack at T. The next grant is possible at T+1.
- If a requester drops its request before being granted, no access is issued for it.

## Configuration
- `SRAM_ARB_RR_EN` defined:
  - Two-way round-robin arbitration.
  - When both requesters are pending in IDLE, the one not granted last wins.
  - The last-grant pointer resets to DMA, so the CPU wins the first tie.
  - A single pending requester always wins.
- `SRAM_ARB_RR_EN` undefined: fixed priority, CPU over DMA. There is no pointer register.

## Structure
- Package `sram_arb_pkg`:
  - State enum with encodings IDLE=0, CPU_RDATA=1, CPU_HOLD=2, DMA_RDATA=3.
  - Grant-select localparams GNT_NONE, GNT_CPU, GNT_DMA.
- Sub-module `sram_arb_grant`: takes the CPU and DMA pending flags and an IDLE qualifier, and returns the grant select. It holds the round-robin pointer when `SRAM_ARB_RR_EN` is defined. The FSM and datapath stay in `sram_arbiter`.

## Test plan
- CPU write then read:
  - Stimulus: CPU writes 0xA5 to 0x0123, then reads 0x0123.
  - Response: write has wait high exactly 1 cycle; read has wait high 2 cycles; `cpu_rdata`=0xA5 when wait drops.
- DMA burst:
  - Stimulus: `dma_req` held for 4 writes to 0x0200–0x0203 (data 0x10–0x13), then 4 reads.
  - Response: writes get 4 consecutive acks; reads return 0x10–0x13 with each `dma_rvalid` at ack+2.
- Collision, fixed priority:
  - Stimulus: CPU read and DMA write asserted in the same cycle.
  - Response: CPU granted first; DMA ack arrives 3 cycles later.
- Collision, round-robin:
  - Stimulus: CPU and DMA held continuously pending, with `SRAM_ARB_RR_EN` defined.
  - Response: grants alternate CPU, DMA, CPU, DMA.
- Reset mid-read:
  - Stimulus: `rst` asserted in the cycle after a DMA read ack.
  - Response: no `dma_rvalid`; all outputs 0; next request after reset served normally.
